// File: rtl/doc_mixer_if.sv
// Sample-stream and stereo-output bundle for doc_mixer.
// The DOC side drives samples and takes frames; the slave modport is the mixer.
interface doc_mixer_if;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic [3:0]  ca_in;
  logic        frame_end;
  logic [15:0] left_out;
  logic [15:0] right_out;
  logic        out_valid;
  logic        out_ready;
  logic        clip;
  logic        overrun;
  logic        clear_flags;

  modport master (
    output sample_valid, sample_in, ca_in, frame_end, out_ready, clear_flags,
    input  left_out, right_out, out_valid, clip, overrun
  );

  modport slave (
    input  sample_valid, sample_in, ca_in, frame_end, out_ready, clear_flags,
    output left_out, right_out, out_valid, clip, overrun
  );
endinterface

// File: rtl/doc_mixer.sv
// Sums one DOC scan of oscillator samples into L/R, scales, saturates; frame out 1 clk after frame_end.
// Unconsumed frames are overwritten by the next one (flagged as overrun); no stall toward the DOC.
module doc_mixer #(
  parameter int ACC_W  = 21,
  parameter int SHIFT  = 2,
  parameter int STEREO = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  doc_mixer_if.slave bus
);

  typedef enum logic {SYNC, ACC} state_t;

  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-32768);

  state_t                  state;
  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic signed [ACC_W-1:0] smp, sum_l, sum_r;
  logic                    to_l, to_r, load;
  logic [16:0]             res_l, res_r;
  logic [15:0]             left_q, right_q;
  logic                    valid_q, clip_q, overrun_q;
  logic [2:0]              ca_unused;

  // {clipped, value} after scaling the closing sum
  function automatic logic [16:0] scale_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if (s > MAXV)
      return {1'b1, 16'h7FFF};
    else if (s < MINV)
      return {1'b1, 16'h8000};
    else
      return {1'b0, s[15:0]};
  endfunction

  assign ca_unused = bus.ca_in[3:1];
  assign smp   = {{(ACC_W-16){bus.sample_in[15]}}, bus.sample_in};
  assign to_l  = bus.sample_valid && ((STEREO == 0) || !bus.ca_in[0]);
  assign to_r  = bus.sample_valid && ((STEREO == 0) ||  bus.ca_in[0]);

  // A sample arriving with frame_end belongs to the closing frame.
  assign sum_l = acc_l + (to_l ? smp : '0);
  assign sum_r = acc_r + (to_r ? smp : '0);
  assign res_l = scale_sat(sum_l);
  assign res_r = scale_sat(sum_r);
  assign load  = (state == ACC) && bus.frame_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SYNC;
      acc_l     <= '0;
      acc_r     <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        SYNC: begin
          if (bus.frame_end) begin
            acc_l <= '0;
            acc_r <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (bus.frame_end) begin
            acc_l   <= '0;
            acc_r   <= '0;
            left_q  <= res_l[15:0];
            right_q <= res_r[15:0];
          end else begin
            acc_l <= sum_l;
            acc_r <= sum_r;
          end
        end
        default: state <= SYNC;
      endcase
      valid_q   <= load | (valid_q & ~bus.out_ready);
      overrun_q <= (load & valid_q & ~bus.out_ready) | (overrun_q & ~bus.clear_flags);
      clip_q    <= (load & (res_l[16] | res_r[16])) | (clip_q & ~bus.clear_flags);
    end
  end

  assign bus.left_out  = left_q;
  assign bus.right_out = right_q;
  assign bus.out_valid = valid_q;
  assign bus.clip      = clip_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_doc_mixer.sv
// Drives a stereo and a mono doc_mixer with the same sample stream; a frame-level
// model feeds per-DUT expected-frame queues that a negedge monitor drains.
module tb_doc_mixer;
  localparam int SH = 2;

  typedef struct {
    int l;
    int r;
  } frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        t_sv = 1'b0, t_fe = 1'b0, t_rdy = 1'b0, t_clr = 1'b0;
  logic [15:0] t_s = '0;
  logic [3:0]  t_ca = '0;

  doc_mixer_if bs ();
  doc_mixer_if bm ();

  assign bs.sample_valid = t_sv;
  assign bs.sample_in    = t_s;
  assign bs.ca_in        = t_ca;
  assign bs.frame_end    = t_fe;
  assign bs.out_ready    = t_rdy;
  assign bs.clear_flags  = t_clr;
  assign bm.sample_valid = t_sv;
  assign bm.sample_in    = t_s;
  assign bm.ca_in        = t_ca;
  assign bm.frame_end    = t_fe;
  assign bm.out_ready    = t_rdy;
  assign bm.clear_flags  = t_clr;

  doc_mixer #(.ACC_W(21), .SHIFT(SH), .STEREO(1)) dut_s (.clk(clk), .reset_n(reset_n), .bus(bs.slave));
  doc_mixer #(.ACC_W(21), .SHIFT(SH), .STEREO(0)) dut_m (.clk(clk), .reset_n(reset_n), .bus(bm.slave));

  int     n_chk = 0, n_fail = 0;
  frame_t qs[$], qm[$];
  int     sum_l = 0, sum_r = 0;
  bit     synced = 0;
  bit     clip_s = 0, clip_m = 0, ovr_s = 0, ovr_m = 0;
  bit     run = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int scl(input int v);
    int t = v >>> SH;
    if (t > 32767) return 32767;
    if (t < -32768) return -32768;
    return t;
  endfunction

  function automatic bit clipped(input int v);
    return ((v >>> SH) > 32767) || ((v >>> SH) < -32768);
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'(signed'(v));
  endfunction

  task automatic model_reset();
    qs.delete();
    qm.delete();
    sum_l = 0; sum_r = 0; synced = 0;
    clip_s = 0; clip_m = 0; ovr_s = 0; ovr_m = 0;
  endtask

  // One clock of stimulus; the model advances right after the sampling edge.
  task automatic step(input bit v, input logic [15:0] s, input logic [3:0] ca,
                      input bit fe, input bit rdy, input bit clr);
    frame_t fs, fm;
    bit load, cs, cm, ov;
    t_sv = v; t_s = s; t_ca = ca; t_fe = fe; t_rdy = rdy; t_clr = clr;
    @(posedge clk);
    load = 0; cs = 0; cm = 0;
    if (synced && v) begin
      if (ca[0]) sum_r += s16(s);
      else       sum_l += s16(s);
    end
    if (fe) begin
      if (synced) begin
        fs.l = scl(sum_l);
        fs.r = scl(sum_r);
        fm.l = scl(sum_l + sum_r);
        fm.r = fm.l;
        cs = clipped(sum_l) || clipped(sum_r);
        cm = clipped(sum_l + sum_r);
        load = 1;
      end
      synced = 1;
      sum_l = 0; sum_r = 0;
    end
    ov = load && !rdy && (qs.size() != 0);
    if (ov) begin
      void'(qs.pop_front());
      void'(qm.pop_front());
    end
    ovr_s  = ov | (ovr_s & !clr);
    ovr_m  = ov | (ovr_m & !clr);
    clip_s = (load && cs) | (clip_s & !clr);
    clip_m = (load && cm) | (clip_m & !clr);
    if (load) begin
      qs.push_back(fs);
      qm.push_back(fm);
    end
    #1;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, rdy, 0);
  endtask

  // Scoreboard monitor: validity, frame contents and flags against the model.
  always @(negedge clk) begin
    if (run) begin
      chk("valid_s", int'(bs.out_valid), int'(qs.size() != 0));
      chk("valid_m", int'(bm.out_valid), int'(qm.size() != 0));
      if (bs.out_valid && qs.size() != 0) begin
        chk("left_s",  s16(bs.left_out),  qs[0].l);
        chk("right_s", s16(bs.right_out), qs[0].r);
        if (bs.out_ready) void'(qs.pop_front());
      end
      if (bm.out_valid && qm.size() != 0) begin
        chk("left_m",  s16(bm.left_out),  qm[0].l);
        chk("right_m", s16(bm.right_out), qm[0].r);
        if (bm.out_ready) void'(qm.pop_front());
      end
      chk("clip_s",    int'(bs.clip),    int'(clip_s));
      chk("clip_m",    int'(bm.clip),    int'(clip_m));
      chk("overrun_s", int'(bs.overrun), int'(ovr_s));
      chk("overrun_m", int'(bm.overrun), int'(ovr_m));
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_left"},  int'(bs.left_out),  0);
    chk({tag, "_right"}, int'(bs.right_out), 0);
    chk({tag, "_valid"}, int'(bs.out_valid), 0);
    chk({tag, "_clip"},  int'(bs.clip),      0);
    chk({tag, "_ovr"},   int'(bs.overrun),   0);
    chk({tag, "_mvalid"}, int'(bm.out_valid), 0);
  endtask

  initial begin
    #3;
    check_reset_outputs("rst");
    @(posedge clk);
    #1 reset_n = 1'b1;
    run = 1;

    // Partial first scan is dropped, then a normal frame
    step(1, 16'h1000, 4'h0, 0, 0, 0);
    step(0, '0, '0, 1, 0, 0);
    idle(0, 2);
    step(1, 16'h1000, 4'h0, 0, 0, 0);
    step(1, 16'h2000, 4'h0, 0, 0, 0);
    step(1, 16'hFC00, 4'h1, 0, 0, 0);
    step(0, '0, '0, 1, 0, 0);
    idle(0, 2);
    idle(1, 1);

    // Saturation both directions
    for (int i = 0; i < 32; i++) step(1, 16'h7FFF, 4'h0, 0, 1, 0);
    step(0, '0, '0, 1, 1, 0);
    for (int i = 0; i < 32; i++) step(1, 16'h8000, 4'h1, 0, 1, 0);
    step(0, '0, '0, 1, 1, 0);
    idle(1, 2);
    step(0, '0, '0, 0, 1, 1);

    // Sample coincident with frame_end closes with that frame
    step(1, 16'h0400, 4'h1, 1, 1, 0);
    step(1, 16'h0400, 4'h1, 0, 1, 0);
    step(0, '0, '0, 1, 1, 0);
    idle(1, 1);

    // Backpressure: overwrite, clear, then transfer-on-load
    step(1, 16'h0123, 4'h0, 0, 0, 0);
    step(0, '0, '0, 1, 0, 0);
    step(1, 16'h0456, 4'h1, 0, 0, 0);
    step(0, '0, '0, 1, 0, 0);
    idle(0, 2);
    step(0, '0, '0, 0, 0, 1);
    idle(1, 1);
    step(1, 16'h0800, 4'h1, 0, 0, 0);
    step(0, '0, '0, 1, 0, 0);
    step(1, 16'h0100, 4'h0, 0, 0, 0);
    step(0, '0, '0, 1, 1, 0);
    step(0, '0, '0, 1, 1, 0);
    idle(1, 2);

    // Randomised scans with random backpressure and flag clears
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++)
        step(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
      step(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 1,
           1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    end
    idle(1, 2);

    // Mid-scan async reset discards the partial sum
    step(1, 16'h4000, 4'h0, 0, 1, 0);
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(1, 16'h0200, 4'h0, 0, 1, 0);
    step(0, '0, '0, 1, 1, 0);
    step(1, 16'h0100, 4'h0, 0, 1, 0);
    step(0, '0, '0, 1, 0, 0);
    idle(1, 3);

    run = 0;
    chk("drained_s", qs.size(), 0);
    chk("drained_m", qm.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/doc_mixer.md
Name: doc_mixer

Overview:
Downstream stage of the Ensoniq DOC sound generator. It consumes the per-oscillator signed sample stream and channel-assign bits the DOC produces once per oscillator slot. It sums the samples into left and right frame accumulators over one DOC scan, then scales and saturates them. Once per scan it presents one stereo 16-bit sample to the audio output path over a valid/ready handshake.

Parameters:
ACC_W, 21, accumulator width in bits. Covers 32 full-scale signed 16-bit samples without overflow.
SHIFT, 2, arithmetic right shift applied to each accumulator at frame end.
STEREO, 1, 1 = route by ca_in[0]; 0 = every sample goes to both channels.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
sample_valid  input  1  one-cycle strobe; sample_in and ca_in are valid this cycle
sample_in  input  16  signed oscillator sample; a halted oscillator delivers 0
ca_in  input  4  channel-assign bits for this sample; only bit 0 is used
frame_end  input  1  one-cycle strobe when the DOC begins its refresh slots, marking end of scan
left_out  output  16  signed left sample
right_out  output  16  signed right sample
out_valid  output  1  left_out and right_out hold an unconsumed frame
out_ready  input  1  consumer accepts the frame when out_valid and out_ready are both high
clip  output  1  sticky; set when any frame saturated
overrun  output  1  sticky; set when a frame was overwritten before it was consumed
clear_flags  input  1  synchronous clear of clip and overrun

Behaviour:
- Reset (async, reset_n=0): left_out=0, right_out=0, out_valid=0, clip=0, overrun=0. Both accumulators are cleared and the FSM enters SYNC. Reset mid-frame discards all partial sums.
- FSM states: SYNC, ACC.
  - SYNC ignores sample_valid. When frame_end=1, it clears the accumulators and moves to ACC. No output is produced, so the partial first scan is dropped.
  - ACC stays in ACC.
- Routing in ACC when sample_valid=1:
  - STEREO=1: ca_in[0]=0 adds sample_in, sign-extended to ACC_W, to acc_l. ca_in[0]=1 adds it to acc_r.
  - STEREO=0: the sample is added to both accumulators.
- Frame end in ACC (frame_end=1):
  - Compute final sums. If sample_valid is also high that cycle, the sample is included in the closing frame.
  - Each sum is arithmetically shifted right by SHIFT, then saturated to [-32768, 32767].
  - The results are registered into left_out and right_out on the next clock edge, and out_valid is set to 1 on that edge.
  - Accumulators restart from 0 on that edge. No sample is lost or double-counted across the frame boundary.
- Latency: out_valid rises exactly 1 clock after the frame_end cycle.
- Handshake: the output holds steady while out_valid=1 and out_ready=0. Transfer happens on a clock edge with both high; out_valid then falls unless a new frame loads on the same edge.
- Overrun: a new frame loads while out_valid=1 and out_ready=0 in that cycle.
  - The new frame overwrites the outputs, out_valid stays 1, and overrun is set.
  - If out_ready=1 that cycle, the old frame transfers and the new one loads; there is no overrun.
- clip: set when either channel saturates at load.
- clear_flags: clears both sticky flags. If a set condition occurs in the same cycle, the set wins.
- Arithmetic: all additions are signed ACC_W-bit. Overflow cannot occur with at most 32 samples per scan at ACC_W=21.
- frame_end on consecutive cycles: the second one produces a frame of zeros. This is legal.

Test Plan:
1. Reset, then samples before the first frame_end: send 0x1000 with ca=0, then frame_end → no out_valid. The next scan sends 0x1000 (ca=0), 0x2000 (ca=0), 0xFC00 (ca=1), then frame_end → 1 clock later out_valid=1, left_out=0x0C00, right_out=0xFF00.
2. Saturation: 32 samples of 0x7FFF with ca=0, then frame_end → left_out=0x7FFF, clip=1. 32 samples of 0x8000 with ca=1 → right_out=0x8000 (-1048576>>2 = -262144 saturates), clip stays 1.
3. Boundary: sample 0x0400 (ca=1) arrives in the same cycle as frame_end → it lands in the closing frame, right_out=0x0100. A sample 0x0400 on the next cycle lands in the next frame.
4. Backpressure: hold out_ready=0 across two frame_ends → the second frame overwrites, overrun=1, out_valid stays 1. Pulse clear_flags → overrun=0. Out_ready=1 on the same edge as a load → no overrun.
5. STEREO=0: sample 0x0800 with ca=1, then frame_end → left_out=right_out=0x0200.
6. Assert reset_n low mid-scan after 0x4000 has been accumulated → outputs and flags are 0 immediately (async). After release, the FSM needs a frame_end to resync, and the first emitted frame excludes 0x4000.
